// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU data-memory interface.
// Accepts one load/store at a time, holds it for a fixed number of wait
// states, then returns formatted load data or a fault indication.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_we, req_funct3    - store select and RISC-V load/store funct3
//   req_addr, req_wdata   - byte address and store data (low lanes)
//   resp_valid/resp_ready - response handshake
//   resp_rdata            - formatted load data, 0 for stores and faults
//   resp_fault            - illegal request, no memory side effect
module dmem_responder #(
   parameter int n     = 32,
   parameter int depth = 256,
   parameter int lat   = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [2:0]   req_funct3,
   input  logic [n-1:0] req_addr,
   input  logic [n-1:0] req_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [n-1:0] resp_rdata,
   output logic         resp_fault
);

   localparam int AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int CW = (lat > 0) ? $clog2(lat + 1) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                     input logic [n-1:0] a);
      logic bad_f3;
      logic misal;
      logic oob;
      if (we) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
      else    bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misal = ((f3[1:0] == 2'b01) && a[0]) ||
              ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
      oob   = (a[n-1:2] >= (n-2)'(depth));
      return bad_f3 | misal | oob;
   endfunction

   // Replicate the low store lanes so any byte enable picks the right byte.
   function automatic logic [n-1:0] store_lanes(input logic [2:0] f3,
                                                input logic [n-1:0] w);
      case (f3[1:0])
         2'b00:   return {4{w[7:0]}};
         2'b01:   return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3,
                                           input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [n-1:0] fmt_load(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [n-1:0] w);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [n-1:0]       r;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{(n-8){b[7]}}, b};
         3'b100:  r = {{(n-8){1'b0}}, b};
         3'b001:  r = {{(n-16){h[15]}}, h};
         3'b101:  r = {{(n-16){1'b0}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   logic [n-1:0]  mem [depth];

   logic [1:0]    state;
   logic [CW-1:0] cnt;

   logic          we_p0;
   logic [2:0]    f3_p0;
   logic [AW-1:0] idx_p0;
   logic [1:0]    off_p0;
   logic [n-1:0]  wlane_p0;
   logic [3:0]    be_p0;
   logic          fault_p0;

   logic [n-1:0]  rdata_p1;
   logic          fault_p1;

   logic          accept;
   logic          finish;

   assign accept = (state == IDLE) && req_valid;
   // Last WAIT cycle: the edge that ends it enters RESP.
   assign finish = (state == WAIT) && (cnt == '0);

   // ---- Stage p0: request capture (data only, not reset) ----
   always_ff @(posedge clock) begin
      if (accept) begin
         we_p0    <= req_we;
         f3_p0    <= req_funct3;
         idx_p0   <= req_addr[AW+1:2];
         off_p0   <= req_addr[1:0];
         wlane_p0 <= store_lanes(req_funct3, req_wdata);
         be_p0    <= store_be(req_funct3, req_addr[1:0]);
         fault_p0 <= is_fault(req_we, req_funct3, req_addr);
      end
   end

   // Storage: a store commits on the edge entering RESP, unless reset wins.
   always_ff @(posedge clock) begin
      if (!reset && finish && we_p0 && !fault_p0) begin
         for (int i = 0; i < 4; i++) begin
            if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wlane_p0[8*i +: 8];
         end
      end
   end

   // ---- Stage p1: control and registered response ----
   // WAIT is entered with cnt = lat and left once cnt is already 0, so a
   // request spends lat+1 cycles there and responds after edge t+lat+1.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rdata_p1 <= '0;
         fault_p1 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state <= WAIT;
                  cnt   <= CW'(lat);
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state    <= RESP;
                  fault_p1 <= fault_p0;
                  rdata_p1 <= (!we_p0 && !fault_p0) ?
                              fmt_load(f3_p0, off_p0, mem[idx_p0]) : '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_rdata = rdata_p1;
   assign resp_fault = fault_p1;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.n(32), .depth(256), .lat(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Issue one request from IDLE with resp_ready high; returns the response.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic flt);
      int cyc;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!resp_valid) chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
      rd  = resp_rdata;
      flt = resp_fault;
      tick();
   endtask

   logic [31:0] rd;
   logic        flt;
   int          cyc;
   logic        saw_valid;

   initial begin
      vecs[0]  = '{"sw_10",      1'b1, 3'b010, 32'h10,  32'h876543A1, 32'h0,        1'b0};
      vecs[1]  = '{"lb_10",      1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFA1, 1'b0};
      vecs[2]  = '{"lbu_13",     1'b0, 3'b100, 32'h13,  32'h0,        32'h00000087, 1'b0};
      vecs[3]  = '{"lh_12",      1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8765, 1'b0};
      vecs[4]  = '{"sb_11",      1'b1, 3'b000, 32'h11,  32'h000000CC, 32'h0,        1'b0};
      vecs[5]  = '{"lw_10_a",    1'b0, 3'b010, 32'h10,  32'h0,        32'h8765CCA1, 1'b0};
      vecs[6]  = '{"sh_12",      1'b1, 3'b001, 32'h12,  32'h00001234, 32'h0,        1'b0};
      vecs[7]  = '{"lhu_12",     1'b0, 3'b101, 32'h12,  32'h0,        32'h00001234, 1'b0};
      vecs[8]  = '{"lw_12_mis",  1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1};
      vecs[9]  = '{"sh_13_mis",  1'b1, 3'b001, 32'h13,  32'h0000FFFF, 32'h0,        1'b1};
      vecs[10] = '{"lw_400_oob", 1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{"ld_f3_011",  1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
      vecs[12] = '{"st_f3_011",  1'b1, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
      vecs[13] = '{"lw_10_b",    1'b0, 3'b010, 32'h10,  32'h0,        32'h1234CCA1, 1'b0};
      vecs[14] = '{"lh_10",      1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFCCA1, 1'b0};
      vecs[15] = '{"lb_11",      1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFCC, 1'b0};
      vecs[16] = '{"lhu_10",     1'b0, 3'b101, 32'h10,  32'h0,        32'h0000CCA1, 1'b0};
      vecs[17] = '{"sw_3fc",     1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, 32'h0,        1'b0};
      vecs[18] = '{"lw_3fc",     1'b0, 3'b010, 32'h3FC, 32'h0,        32'h0BADF00D, 1'b0};
      vecs[19] = '{"lbu_3ff",    1'b0, 3'b100, 32'h3FF, 32'h0,        32'h0000000B, 1'b0};

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata,          32'd0);
      chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);

      for (int i = 0; i < 20; i++) begin
         xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({vecs[i].name, "_fault"}, {31'd0, flt}, {31'd0, vecs[i].exp_fault});
      end

      // Handshake timing with lat = 2, resp_ready high; edge 0 accepts.
      chk("t_ready_pre", {31'd0, req_ready}, 32'd1);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t_e0_ready", {31'd0, req_ready},  32'd0);
      chk("t_e0_valid", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("t_e1_valid", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("t_e2_valid", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("t_e3_valid", {31'd0, resp_valid}, 32'd1);
      chk("t_e3_ready", {31'd0, req_ready},  32'd0);
      chk("t_e3_rdata", resp_rdata,          32'h1234CCA1);
      tick();
      chk("t_e4_valid", {31'd0, resp_valid}, 32'd0);
      chk("t_e4_ready", {31'd0, req_ready},  32'd1);

      // Backpressure: response held, concurrent store ignored.
      resp_ready = 1'b0;
      req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h13; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("bp_valid_arrive", {31'd0, resp_valid}, 32'd1);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("bp_valid_%0d", k), {31'd0, resp_valid}, 32'd1);
         chk($sformatf("bp_rdata_%0d", k), resp_rdata,          32'h00000012);
         chk($sformatf("bp_ready_%0d", k), {31'd0, req_ready},  32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, req_ready},  32'd1);
      xact(1'b0, 3'b010, 32'h10, 32'h0, rd, flt);
      chk("bp_ignored_store", rd, 32'h1234CCA1);

      // Reset during WAIT discards a pending store.
      xact(1'b1, 3'b010, 32'h20, 32'h0, rd, flt);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_req_ready",  {31'd0, req_ready},  32'd1);
      chk("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mr_resp_rdata", resp_rdata,          32'd0);
      chk("mr_resp_fault", {31'd0, resp_fault}, 32'd0);
      saw_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (resp_valid) saw_valid = 1'b1;
      end
      chk("mr_no_resp", {31'd0, saw_valid}, 32'd0);
      xact(1'b0, 3'b010, 32'h20, 32'h0, rd, flt);
      chk("mr_lw_20_rdata", rd,            32'h00000000);
      chk("mr_lw_20_fault", {31'd0, flt},  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
